// File: rtl/truth_table_sequencer.sv
// Sweeps every N-bit input vector onto two implementations of one Boolean function,
// compares their outputs after SETTLE cycles per vector and reports mismatch results.
module truth_table_sequencer #(
  parameter int unsigned N      = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic         r_a,
  input  logic         r_b,
  output logic [N-1:0] vec,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         aborted,
  output logic [N:0]   mismatch_count,
  output logic [N-1:0] first_fail_vec,
  output logic         fail_seen
);

  localparam int unsigned CW = $clog2(SETTLE + 1);
  localparam logic [N-1:0]  VEC_LAST = {N{1'b1}};
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    mm_q, mm_d;
  logic [N-1:0]  ffv_q, ffv_d;
  logic          fs_q, fs_d;
  logic          pass_q, pass_d;
  logic          aborted_q, aborted_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // State and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      vec_q     <= '0;
      cnt_q     <= '0;
      mm_q      <= '0;
      ffv_q     <= '0;
      fs_q      <= 1'b0;
      pass_q    <= 1'b0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      mm_q      <= mm_d;
      ffv_q     <= ffv_d;
      fs_q      <= fs_d;
      pass_q    <= pass_d;
      aborted_q <= aborted_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and result update
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    mm_d      = mm_q;
    ffv_d     = ffv_q;
    fs_d      = fs_q;
    pass_d    = pass_q;
    aborted_d = aborted_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d   = ST_APPLY;
          vec_d     = '0;
          cnt_d     = '0;
          mm_d      = '0;
          ffv_d     = '0;
          fs_d      = 1'b0;
          pass_d    = 1'b0;
          aborted_d = 1'b0;
        end
      end
      ST_APPLY: begin
        if (abort) begin
          // The compare due on this edge, if any, is dropped
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
          pass_d    = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          if (r_a != r_b) begin
            mm_d = mm_q + (N+1)'(1);
            if (!fs_q) begin
              ffv_d = vec_q;
              fs_d  = 1'b1;
            end
          end
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
            pass_d  = (mm_d == '0);
          end else begin
            vec_d = vec_q + N'(1);
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_APPLY);
    done_d = (state_d == ST_DONE);
  end

  assign vec            = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign aborted        = aborted_q;
  assign mismatch_count = mm_q;
  assign first_fail_vec = ffv_q;
  assign fail_seen      = fs_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: table-driven full sweeps with a result scoreboard,
// plus hand sequences for abort, async reset and a longer settle time.
module tb_truth_table_sequencer;

  localparam int unsigned N = 2;

  typedef struct {
    int unsigned mode;     // 0:r_b=AND 1:r_b=OR 2:r_b=0 3:r_b=NAND
    int unsigned exp_mm;
    int unsigned exp_ffv;
    int unsigned exp_fs;
    int unsigned exp_pass;
  } vec_rec_t;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  logic reset = 1'b0;

  // Instance with SETTLE=1
  logic         start1 = 1'b0, abort1 = 1'b0, ra1, rb1;
  int unsigned  mode1 = 0;
  logic [N-1:0] vec1, ffv1;
  logic         busy1, done1, pass1, aborted1, fs1;
  logic [N:0]   mm1;

  // Instance with SETTLE=3
  logic         start3 = 1'b0, abort3 = 1'b0, ra3, rb3;
  logic [N-1:0] vec3, ffv3;
  logic         busy3, done3, pass3, aborted3, fs3;
  logic [N:0]   mm3;

  vec_rec_t exp_q[$];

  always #5 clk = ~clk;

  truth_table_sequencer #(.N(N), .SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1), .r_a(ra1), .r_b(rb1),
    .vec(vec1), .busy(busy1), .done(done1), .pass(pass1), .aborted(aborted1),
    .mismatch_count(mm1), .first_fail_vec(ffv1), .fail_seen(fs1)
  );

  truth_table_sequencer #(.N(N), .SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .abort(abort3), .r_a(ra3), .r_b(rb3),
    .vec(vec3), .busy(busy3), .done(done3), .pass(pass3), .aborted(aborted3),
    .mismatch_count(mm3), .first_fail_vec(ffv3), .fail_seen(fs3)
  );

  // Implementations under comparison: A is always AND, B is selected by mode1
  always_comb begin
    ra1 = vec1[1] & vec1[0];
    case (mode1)
      0:       rb1 = vec1[1] & vec1[0];
      1:       rb1 = vec1[1] | vec1[0];
      2:       rb1 = 1'b0;
      default: rb1 = ~(vec1[1] & vec1[0]);
    endcase
    ra3 = vec3[1] & vec3[0];
    rb3 = ~(~vec3[1] | ~vec3[0]);
  end

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full sweep on dut1: per-cycle vec/busy checks, results popped from the scoreboard at done
  task automatic run_sweep1(input vec_rec_t r);
    vec_rec_t e;
    int c;
    bit got;
    mode1  = r.mode;
    start1 = 1'b1;
    exp_q.push_back(r);
    tick();
    start1 = 1'b0;
    c = 0;
    got = 1'b0;
    while (!got && c < 20) begin
      if (done1) begin
        got = 1'b1;
        e = exp_q.pop_front();
        check("done_latency", c, 4);
        check("busy_at_done", busy1, 0);
        check("mismatch_count", mm1, e.exp_mm);
        check("first_fail_vec", ffv1, e.exp_ffv);
        check("fail_seen", fs1, e.exp_fs);
        check("pass", pass1, e.exp_pass);
      end else begin
        if (c < 4) begin
          check("vec_step", vec1, c);
          check("busy_in_sweep", busy1, 1);
        end
        tick();
        c++;
      end
    end
    if (!got) check("done_timeout", 0, 1);
    tick();
    check("done_one_cycle", done1, 0);
    check("vec_holds_last", vec1, 3);
    tick();
    check("results_hold_mm", mm1, r.exp_mm);
    check("results_hold_pass", pass1, r.exp_pass);
  endtask

  initial begin
    vec_rec_t tbl[5];
    int c;
    bit got;

    tbl[0] = '{mode: 0, exp_mm: 0, exp_ffv: 0, exp_fs: 0, exp_pass: 1};
    tbl[1] = '{mode: 1, exp_mm: 2, exp_ffv: 1, exp_fs: 1, exp_pass: 0};
    tbl[2] = '{mode: 2, exp_mm: 1, exp_ffv: 3, exp_fs: 1, exp_pass: 0};
    tbl[3] = '{mode: 3, exp_mm: 4, exp_ffv: 0, exp_fs: 1, exp_pass: 0};
    tbl[4] = '{mode: 0, exp_mm: 0, exp_ffv: 0, exp_fs: 0, exp_pass: 1};

    #1 reset = 1'b1;
    #2;
    check("rst_vec", vec1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_pass", pass1, 0);
    check("rst_mm", mm1, 0);
    check("rst_fs", fs1, 0);
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_sweep1(tbl[i]);

    // Abort while vec=01 against OR: the vec=01 compare must be discarded
    mode1  = 1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    check("pre_abort_vec", vec1, 1);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    check("abort_busy", busy1, 0);
    check("abort_flag", aborted1, 1);
    check("abort_pass", pass1, 0);
    check("abort_mm", mm1, 0);
    check("abort_fs", fs1, 0);
    for (int i = 0; i < 6; i++) begin
      check("abort_no_done", done1, 0);
      tick();
    end

    // start and abort together in IDLE: nothing happens
    start1 = 1'b1;
    abort1 = 1'b1;
    tick();
    start1 = 1'b0;
    abort1 = 1'b0;
    check("start_abort_busy", busy1, 0);
    check("start_abort_flag", aborted1, 1);
    tick();
    check("start_abort_idle", busy1, 0);

    // Asynchronous reset mid-sweep at vec=10
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    check("pre_reset_vec", vec1, 2);
    #2 reset = 1'b1;
    #1;
    check("async_rst_vec", vec1, 0);
    check("async_rst_busy", busy1, 0);
    check("async_rst_aborted", aborted1, 0);
    check("async_rst_done", done1, 0);
    tick();
    reset = 1'b0;
    tick();
    run_sweep1(tbl[1]);

    // SETTLE=3: each vector held 3 cycles; a second start mid-sweep is ignored
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    c = 0;
    got = 1'b0;
    while (!got && c < 40) begin
      if (done3) begin
        got = 1'b1;
        check("s3_done_latency", c, 12);
        check("s3_busy_at_done", busy3, 0);
        check("s3_pass", pass3, 1);
        check("s3_mm", mm3, 0);
        check("s3_fs", fs3, 0);
      end else begin
        if (c < 12) begin
          check("s3_vec", vec3, c / 3);
          check("s3_busy", busy3, 1);
        end
        start3 = (c == 5);
        tick();
        c++;
      end
    end
    start3 = 1'b0;
    if (!got) check("s3_done_timeout", 0, 1);
    tick();
    check("s3_back_idle", busy3, 0);
    check("s3_done_pulse", done3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
